// File: rtl/window_pkg.sv
// window_pkg: shared types for the 3x3 sliding-window generator.
// Pixel/window types and the frame FSM state encoding.
package window_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;

  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACTIVE
  } win_state_e;

endpackage

// File: rtl/window_line_buffer.sv
// window_line_buffer: one-row storage holding the two previous rows packed.
// Single address, synchronous write, read returns the pre-write contents.
module window_line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 valid-mode window generator.
// Define WINDOW_GEN_EOF_EN to add the eof_o last-window flag.
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [PIXEL_WIDTH-1:0]           pixel_i,
  input  logic                             pixel_valid_i,
  input  logic                             sof_i,
  output logic [2:0][2:0][PIXEL_WIDTH-1:0] window_o,
  output logic                             window_valid_o,
`ifdef WINDOW_GEN_EOF_EN
  output logic                             eof_o,
`endif
  output logic                             busy_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  win_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic accept, last_px, emit;
  logic [PIXEL_WIDTH-1:0] lb1_rd, lb2_rd;
  logic [2*PIXEL_WIDTH-1:0] lb_rd, lb_wr;

  // sof_i restarts the frame at (0,0) from any state
  always_comb begin
    accept  = pixel_valid_i && (sof_i || (state_q != IDLE));
    col_eff = sof_i ? '0 : col_q;
    row_eff = sof_i ? '0 : row_q;
    last_px = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    emit    = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (last_px) begin
        col_d   = '0;
        row_d   = '0;
        state_d = IDLE;
      end else begin
        if (col_eff == COL_LAST) begin
          col_d = '0;
          row_d = row_eff + 1'b1;
        end else begin
          col_d = col_eff + 1'b1;
          row_d = row_eff;
        end
        state_d = (row_d >= RW'(2)) ? ACTIVE : FILL;
      end
    end
  end

  assign lb1_rd = lb_rd[PIXEL_WIDTH-1:0];
  assign lb2_rd = lb_rd[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
  assign lb_wr  = {lb1_rd, pixel_i};

  window_line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(2 * PIXEL_WIDTH),
    .AW   (CW)
  ) u_lb (
    .clk_i  (clk_i),
    .we_i   (accept),
    .addr_i (col_eff),
    .wdata_i(lb_wr),
    .rdata_o(lb_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      window_o       <= '0;
      window_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_o <= emit;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          window_o[r][0] <= window_o[r][1];
          window_o[r][1] <= window_o[r][2];
        end
        window_o[0][2] <= lb2_rd;
        window_o[1][2] <= lb1_rd;
        window_o[2][2] <= pixel_i;
      end
    end
  end

`ifdef WINDOW_GEN_EOF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eof_o <= 1'b0;
    end else begin
      eof_o <= emit && last_px;
    end
  end
`endif

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed bench for window_gen_3x3 (4x4 and 28x28).
// Define WINDOW_GEN_EOF_EN to also exercise eof_o.
module tb_window_gen_3x3;

  typedef logic [2:0][2:0][7:0] win_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] pix4, pix28;
  logic pv4, sof4, pv28, sof28;
  win_t w4, w28;
  logic v4, busy4, v28, busy28;
  logic eof4, eof28;

  window_gen_3x3 #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4),
    .PIXEL_WIDTH(8)
  ) u4 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pixel_i       (pix4),
    .pixel_valid_i (pv4),
    .sof_i         (sof4),
    .window_o      (w4),
    .window_valid_o(v4),
`ifdef WINDOW_GEN_EOF_EN
    .eof_o         (eof4),
`endif
    .busy_o        (busy4)
  );

  window_gen_3x3 #(
    .IMG_WIDTH  (28),
    .IMG_HEIGHT (28),
    .PIXEL_WIDTH(8)
  ) u28 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pixel_i       (pix28),
    .pixel_valid_i (pv28),
    .sof_i         (sof28),
    .window_o      (w28),
    .window_valid_o(v28),
`ifdef WINDOW_GEN_EOF_EN
    .eof_o         (eof28),
`endif
    .busy_o        (busy28)
  );

`ifndef WINDOW_GEN_EOF_EN
  assign eof4  = 1'b0;
  assign eof28 = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_cyc;

  win_t wq[$];
  int   cq[$];
  logic eq[$];
  int   consec = 0;
  int   hold_bad = 0;
  int   eof_cnt = 0;
  logic v4_prev = 1'b0;
  win_t w4_prev = '0;
  logic pv_edge4 = 1'b0;

  int e28 = 0;
  int bad28 = 0;
  int ctr_bad = 0;

  function automatic win_t mkwin(int r, int c, int wid, int base);
    win_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i][j] = 8'(((r - 2 + i) * wid) + (c - 2 + j) + base);
    return m;
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pv_edge4 <= pv4;
  end

  always @(negedge clk) begin
    if (rst_n && v4) begin
      wq.push_back(w4);
      cq.push_back(cyc);
      eq.push_back(eof4);
    end
    if (rst_n && v4 && v4_prev) consec <= consec + 1;
    if (rst_n && !pv_edge4 && (w4 !== w4_prev))
      hold_bad <= hold_bad + 1;
    if (rst_n && eof4) eof_cnt <= eof_cnt + 1;
    v4_prev <= v4;
    w4_prev <= w4;
  end

  always @(negedge clk) begin : cap28
    int r, c, e;
    if (rst_n && v28) begin
      e = e28 % 676;
      r = 2 + e / 26;
      c = 2 + e % 26;
      if (w28 !== mkwin(r, c, 28, 0)) bad28 <= bad28 + 1;
      if (w28[1][1] !== 8'((r - 1) * 28 + c - 1))
        ctr_bad <= ctr_bad + 1;
      e28 <= e28 + 1;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send4(input int val, input bit sof, input bit vld);
    @(negedge clk);
    pix4 = 8'(val);
    sof4 = sof;
    pv4  = vld;
    last_cyc = cyc;
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge clk);
      pv4  = 1'b0;
      sof4 = 1'b0;
      pix4 = 8'hEE;
    end
  endtask

  task automatic send28(input int val, input bit sof);
    @(negedge clk);
    pix28 = 8'(val);
    sof28 = sof;
    pv28  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int b, c0, h0, ec0;
    int dcyc[16];
    int pk[4];
    pk = '{10, 11, 14, 15};
    rst_n = 1'b0;
    pv4 = 0; sof4 = 0; pix4 = 0;
    pv28 = 0; sof28 = 0; pix28 = 0;
    repeat (3) @(negedge clk);
    chk("rst_win", 72'(w4), 72'(0));
    chk("rst_valid", 72'(v4), 72'(0));
    chk("rst_busy", 72'(busy4), 72'(0));
    chk("rst_eof", 72'(eof4), 72'(0));
    rst_n = 1'b1;

    // back-to-back 4x4 frame
    b = wq.size();
    for (int k = 0; k < 16; k++) begin
      send4(k, k == 0, 1'b1);
      dcyc[k] = last_cyc;
    end
    chk("t1_busy_mid", 72'(busy4), 72'(1));
    idle4(1);
    chk("t1_busy_end", 72'(busy4), 72'(0));
    idle4(2);
    chk("t1_count", 72'(wq.size()), 72'(b + 4));
    if (wq.size() >= b + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t1_lat%0d", i), 72'(cq[b + i]),
            72'(dcyc[pk[i]] + 1));
        chk($sformatf("t1_win%0d", i), wq[b + i],
            mkwin(2 + i / 2, 2 + i % 2, 4, 0));
      end
      chk("t1_first00", 72'(wq[b][0][0]), 72'(0));
      chk("t1_first12", 72'(wq[b][1][2]), 72'(6));
      chk("t1_first22", 72'(wq[b][2][2]), 72'(10));
      chk("t1_last00", 72'(wq[b + 3][0][0]), 72'(5));
      chk("t1_last22", 72'(wq[b + 3][2][2]), 72'(15));
`ifdef WINDOW_GEN_EOF_EN
      for (int i = 0; i < 4; i++)
        chk($sformatf("eof_pat%0d", i), 72'(eq[b + i]),
            72'(i == 3));
`endif
    end

    // valid toggled every other cycle
    c0 = consec;
    h0 = hold_bad;
    b = wq.size();
    for (int k = 0; k < 16; k++) begin
      send4(k, k == 0, 1'b1);
      send4(8'hEE, 1'b0, 1'b0);
    end
    idle4(3);
    chk("t2_count", 72'(wq.size()), 72'(b + 4));
    if (wq.size() >= b + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t2_win%0d", i), wq[b + i],
            mkwin(2 + i / 2, 2 + i % 2, 4, 0));
    chk("t2_consec", 72'(consec), 72'(c0));
    chk("t2_hold", 72'(hold_bad), 72'(h0));

    // stray pixels, then a frame aborted by sof at pixel 6
    for (int k = 0; k < 3; k++) send4(200 + k, 1'b0, 1'b1);
    idle4(1);
    chk("t3_idle_drop", 72'(busy4), 72'(0));
    b = wq.size();
    for (int k = 0; k < 6; k++) send4(100 + k, k == 0, 1'b1);
    for (int k = 0; k < 16; k++) send4(50 + k, k == 0, 1'b1);
    idle4(3);
    chk("t3_count", 72'(wq.size()), 72'(b + 4));
    if (wq.size() >= b + 4) begin
      chk("t3_first", wq[b], mkwin(2, 2, 4, 50));
      chk("t3_first00", 72'(wq[b][0][0]), 72'(50));
      chk("t3_first22", 72'(wq[b][2][2]), 72'(60));
      chk("t3_last", wq[b + 3], mkwin(3, 3, 4, 50));
    end

    // async reset mid-frame
    for (int k = 0; k < 12; k++) send4(k, k == 0, 1'b1);
    @(negedge clk);
    pv4 = 1'b0;
    sof4 = 1'b0;
    chk("t4_pre_valid", 72'(v4), 72'(1));
    rst_n = 1'b0;
    #1;
    chk("t4_rst_win", 72'(w4), 72'(0));
    chk("t4_rst_valid", 72'(v4), 72'(0));
    chk("t4_rst_busy", 72'(busy4), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    b = wq.size();
    for (int k = 0; k < 16; k++) send4(k, 1'b0, 1'b1);
    idle4(3);
    chk("t4_nosof_cnt", 72'(wq.size()), 72'(b));
    chk("t4_nosof_busy", 72'(busy4), 72'(0));
    for (int k = 0; k < 16; k++) send4(k, k == 0, 1'b1);
    idle4(3);
    chk("t4_sof_cnt", 72'(wq.size()), 72'(b + 4));
    if (wq.size() >= b + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t4_win%0d", i), wq[b + i],
            mkwin(2 + i / 2, 2 + i % 2, 4, 0));

`ifdef WINDOW_GEN_EOF_EN
    // frame aborted at pixel 13: no eof until the new frame ends
    ec0 = eof_cnt;
    b = wq.size();
    for (int k = 0; k < 13; k++) send4(k, k == 0, 1'b1);
    for (int k = 0; k < 10; k++) send4(k, k == 0, 1'b1);
    idle4(2);
    chk("eof_abort", 72'(eof_cnt), 72'(ec0));
    for (int k = 10; k < 16; k++) send4(k, 1'b0, 1'b1);
    idle4(3);
    chk("eof_newframe", 72'(eof_cnt), 72'(ec0 + 1));
    chk("eof_cnt_win", 72'(wq.size()), 72'(b + 6));
    if (wq.size() >= b + 6) begin
      chk("eof_ab0", 72'(eq[b]), 72'(0));
      chk("eof_ab1", 72'(eq[b + 1]), 72'(0));
      chk("eof_nf3", 72'(eq[b + 5]), 72'(1));
    end
`else
    ec0 = 0;
`endif

    // two back-to-back 28x28 ramp frames
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 784; k++) begin
        send28(k % 256, k == 0);
        if (f == 1 && k == 28)
          chk("t5_frame1_cnt", 72'(e28), 72'(676 + ec0 * 0));
      end
    @(negedge clk);
    pv28 = 1'b0;
    sof28 = 1'b0;
    chk("t5_busy_end", 72'(busy28), 72'(0));
    repeat (2) @(negedge clk);
    chk("t5_total_cnt", 72'(e28), 72'(1352));
    chk("t5_win_bad", 72'(bad28), 72'(0));
    chk("t5_center_bad", 72'(ctr_bad), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
